// File: rtl/disarm_code_checker_pkg.sv
// Shared types for the bomb disarm game.
// FSM encoding and code geometry.
package disarm_code_checker_pkg;

  localparam int CODE_LEN = 4;
  localparam int DIGIT_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    WON   = 2'd2,
    LOST  = 2'd3
  } state_e;

  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/disarm_code_checker_button_debouncer.sv
// One button lane: 2-flop synchroniser, debounce, rising-edge pulse.
// A bounce restarts the stability counter from zero.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign press = level_q & ~prev_q;

endmodule

// File: rtl/disarm_code_checker.sv
// Four-digit disarm code entry with strike counting.
// Win/lose flags are registered alongside the state.
module disarm_code_checker
  import disarm_code_checker_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [7:0]  SECRET          = 8'b00_01_10_11,
  parameter int unsigned MAX_STRIKES     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       time_over,
  input  logic [3:0] btn,
  output logic       game_won,
  output logic       game_lost,
  output logic [1:0] strikes,
  output logic [2:0] digits_entered
);

  localparam logic [1:0] MAX_S    = 2'(MAX_STRIKES);
  localparam logic [2:0] LAST_IDX = 3'(CODE_LEN - 1);

  logic [3:0] press;
  logic [3:0] sel;
  logic       single;
  digit_t     idx;
  logic [7:0] code;

  state_e     state_q, state_d;
  digit_t     digit_q [CODE_LEN];
  digit_t     digit_d [CODE_LEN];
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] strikes_q, strikes_d;
  logic       won_q, won_d;
  logic       lost_q, lost_d;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .btn_in(btn[i]),
      .press (press[i])
    );
  end

  assign single = $onehot(press);
  assign sel    = single ? press : 4'b0000;

  always_comb begin
    idx = '0;
    unique case (1'b1)
      sel[0]:  idx = 2'd0;
      sel[1]:  idx = 2'd1;
      sel[2]:  idx = 2'd2;
      sel[3]:  idx = 2'd3;
      default: idx = '0;
    endcase
  end

  assign code = {digit_q[0], digit_q[1], digit_q[2], idx};

  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    cnt_d     = cnt_q;
    strikes_d = strikes_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ENTRY;
      end
      ENTRY: begin
        if (time_over) begin
          state_d = LOST;
        end else if (single) begin
          digit_d[cnt_q[1:0]] = idx;
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
            if (code == SECRET) begin
              state_d = WON;
            end else begin
              if (strikes_q != MAX_S) strikes_d = strikes_q + 1'b1;
              if (strikes_d == MAX_S) state_d = LOST;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    won_d  = (state_d == WON);
    lost_d = (state_d == LOST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      strikes_q <= '0;
      won_q     <= 1'b0;
      lost_q    <= 1'b0;
      for (int i = 0; i < CODE_LEN; i++) digit_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      strikes_q <= strikes_d;
      won_q     <= won_d;
      lost_q    <= lost_d;
      for (int i = 0; i < CODE_LEN; i++) digit_q[i] <= digit_d[i];
    end
  end

  assign game_won       = won_q;
  assign game_lost      = lost_q;
  assign strikes        = strikes_q;
  assign digits_entered = cnt_q;

endmodule

// File: tb/tb_disarm_code_checker.sv
// Scoreboard bench: stimulus queues expected output snapshots,
// a monitor pops them on every output change or checkpoint.
module tb_disarm_code_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       time_over = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       game_won, game_lost;
  logic [1:0] strikes;
  logic [2:0] digits_entered;

  disarm_code_checker #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .time_over     (time_over),
    .btn           (btn),
    .game_won      (game_won),
    .game_lost     (game_lost),
    .strikes       (strikes),
    .digits_entered(digits_entered)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         chk;
    int         due;
    logic [6:0] v;
  } exp_t;

  exp_t q[$];
  int   chk_n  = 0;
  bit   mon_en = 1'b0;
  bit   done   = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  localparam logic [6:0] ZERO = 7'd0;

  function automatic logic [6:0] ev(bit w, bit l, int s, int d);
    return {w, l, 2'(s), 3'(d)};
  endfunction

  task automatic push_chg(input logic [6:0] v, input int due);
    exp_t e;
    e.chk = 1'b0; e.due = due; e.v = v;
    q.push_back(e);
  endtask

  task automatic push_now(input logic [6:0] v);
    exp_t e;
    e.chk = 1'b1; e.due = 0; e.v = v;
    q.push_back(e);
    chk_n++;
  endtask

  // Output changes seven edges after btn rises: 2 sync + 4 debounce + 1 FSM.
  task automatic press(input int i, input bit to, input bit chg,
                       input logic [6:0] v);
    int k;
    @(negedge clk);
    btn[i] = 1'b1;
    k = cyc;
    if (chg) push_chg(v, k + 7);
    repeat (6) @(negedge clk);
    if (to) time_over = 1'b1;
    @(negedge clk);
    time_over = 1'b0;
    repeat (5) @(negedge clk);
    btn[i] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset(input bit chg);
    @(negedge clk);
    reset = 1'b1;
    if (chg) push_chg(ZERO, cyc + 1);
    @(negedge clk);
    reset = 1'b0;
    push_now(ZERO);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [6:0] prev, cur;
    exp_t e;
    int seen;
    seen = 0;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      cur = {game_won, game_lost, strikes, digits_entered};
      if (mon_en) begin
        if (cur !== prev) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_change got=%b cyc=%0d", cur, cyc);
          end else begin
            e = q.pop_front();
            if (e.chk || e.v !== cur || e.due != cyc) begin
              bad++;
              $display("FAIL change got=%b@%0d want=%b@%0d chk=%0b",
                       cur, cyc, e.v, e.due, e.chk);
            end
          end
        end
        if (chk_n != seen) begin
          seen++;
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL checkpoint_empty got=%b", cur);
          end else begin
            e = q.pop_front();
            if (!e.chk || e.v !== cur) begin
              bad++;
              $display("FAIL checkpoint got=%b want=%b cyc=%0d",
                       cur, e.v, cyc);
            end
          end
        end
      end
      prev = cur;
      if (done) begin
        while (q.size() != 0) begin
          e = q.pop_front();
          total++;
          bad++;
          $display("FAIL missing got=none want=%b due=%0d", e.v, e.due);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    push_now(ZERO);

    press(0, 0, 0, ZERO);
    push_now(ZERO);

    do_start();
    press(0, 0, 1, ev(0, 0, 0, 1));
    press(1, 0, 1, ev(0, 0, 0, 2));
    press(2, 0, 1, ev(0, 0, 0, 3));
    press(3, 0, 1, ev(1, 0, 0, 0));
    press(1, 0, 0, ZERO);
    do_start();
    @(negedge clk) time_over = 1'b1;
    @(negedge clk) time_over = 1'b0;
    push_now(ev(1, 0, 0, 0));
    do_reset(1);

    do_start();
    for (int s = 1; s <= 3; s++) begin
      press(3, 0, 1, ev(0, 0, s - 1, 1));
      press(3, 0, 1, ev(0, 0, s - 1, 2));
      press(3, 0, 1, ev(0, 0, s - 1, 3));
      press(3, 0, 1, (s < 3) ? ev(0, 0, s, 0) : ev(0, 1, 3, 0));
    end
    press(0, 0, 0, ZERO);
    push_now(ev(0, 1, 3, 0));
    do_reset(1);

    do_start();
    for (int t = 0; t < 10; t++) begin
      @(negedge clk) btn[2] = ~btn[2];
      @(negedge clk);
    end
    @(negedge clk);
    btn[2] = 1'b1;
    k = cyc;
    push_chg(ev(0, 0, 0, 1), k + 7);
    repeat (12) @(negedge clk);
    btn[2] = 1'b0;
    repeat (10) @(negedge clk);

    btn = 4'b0011;
    repeat (12) @(negedge clk);
    btn = 4'b0000;
    repeat (10) @(negedge clk);
    push_now(ev(0, 0, 0, 1));
    do_reset(1);

    do_start();
    press(0, 0, 1, ev(0, 0, 0, 1));
    press(1, 0, 1, ev(0, 0, 0, 2));
    press(2, 0, 1, ev(0, 0, 0, 3));
    press(3, 1, 1, ev(0, 1, 0, 3));
    do_reset(1);

    do_start();
    press(0, 0, 1, ev(0, 0, 0, 1));
    press(1, 0, 1, ev(0, 0, 0, 2));
    do_reset(1);

    repeat (5) @(negedge clk);
    done = 1'b1;
  end

endmodule
